// File: rtl/program_loader_if.sv
// Byte-in / word-out bus of the program loader.
// The loader takes the slave modport; its driver takes the master modport.
interface program_loader_if #(
   parameter int NB_DATA        = 32,
   parameter int NB_BYTE        = 8,
   parameter int NB_ADDR_CUSTOM = 5
);
   logic                      i_start;
   logic [NB_BYTE-1:0]        i_rx_data;
   logic                      i_rx_valid;
   logic                      o_wr_enable;
   logic [NB_ADDR_CUSTOM-1:0] o_wr_addr;
   logic [NB_DATA-1:0]        o_wr_data;
   logic                      o_busy;
   logic                      o_done;
   logic                      o_error;
   logic [NB_ADDR_CUSTOM:0]   o_word_count;
   logic [NB_DATA-1:0]        o_checksum;

   modport master (
      output i_start, i_rx_data, i_rx_valid,
      input  o_wr_enable, o_wr_addr, o_wr_data, o_busy, o_done, o_error,
             o_word_count, o_checksum
   );

   modport slave (
      input  i_start, i_rx_data, i_rx_valid,
      output o_wr_enable, o_wr_addr, o_wr_data, o_busy, o_done, o_error,
             o_word_count, o_checksum
   );
endinterface

// File: rtl/program_loader.sv
// Packs received bytes MSB-first into words and writes them to program memory until HALT.
// Define PROGRAM_LOADER_CHECKSUM_EN to build the running XOR checksum of written words.
module program_loader #(
   parameter int                 NB_DATA        = 32,
   parameter int                 NB_BYTE        = 8,
   parameter int                 NB_ADDR_CUSTOM = 5,
   parameter int                 ROM_DEPTH      = 30,
   parameter logic [NB_DATA-1:0] HALT_WORD      = 32'hFFFF_FFFF
) (
   input logic             i_clock,
   input logic             i_reset,
   program_loader_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERROR} state_t;

   localparam logic [NB_ADDR_CUSTOM-1:0] LAST_ADDR = NB_ADDR_CUSTOM'(ROM_DEPTH - 1);

   state_t                      state;
   state_t                      state_next;
   logic [1:0]                  byte_cnt;
   logic [NB_DATA-NB_BYTE-1:0]  shift;
   logic [NB_ADDR_CUSTOM-1:0]   addr;
   logic [NB_ADDR_CUSTOM:0]     word_count;
   logic                        wr_enable;
   logic [NB_ADDR_CUSTOM-1:0]   wr_addr;
   logic [NB_DATA-1:0]          wr_data;
   logic                        start_load;
   logic                        take_byte;
   logic                        word_ready;
   logic [NB_DATA-1:0]          word_next;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_next = state;
      start_load = 1'b0;
      take_byte  = 1'b0;
      unique case (state)
         ST_LOAD: begin
            take_byte = bus.i_rx_valid;
            // Terminate the cycle after the write, judged on the word just written.
            if (wr_enable && (wr_data == HALT_WORD)) begin
               state_next = ST_DONE;
            end else if (wr_enable && (wr_addr == LAST_ADDR)) begin
               state_next = ST_ERROR;
            end
         end
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (bus.i_start) begin
               start_load = 1'b1;
               state_next = ST_LOAD;
            end
         end
      endcase
   end

   assign word_next  = {shift, bus.i_rx_data};
   assign word_ready = take_byte && (byte_cnt == 2'd3);

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state      <= ST_IDLE;
         byte_cnt   <= '0;
         shift      <= '0;
         addr       <= '0;
         word_count <= '0;
         wr_enable  <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register here sees pre-edge values.
         state     <= state_next;
         wr_enable <= 1'b0;
         if (start_load) begin
            byte_cnt   <= '0;
            shift      <= '0;
            addr       <= '0;
            word_count <= '0;
            wr_addr    <= '0;
         end else if (take_byte) begin
            shift    <= word_next[NB_DATA-NB_BYTE-1:0];
            byte_cnt <= byte_cnt + 2'd1;
            if (word_ready) begin
               wr_enable  <= 1'b1;
               wr_addr    <= addr;
               wr_data    <= word_next;
               addr       <= addr + 1'b1;
               word_count <= word_count + 1'b1;
            end
         end
      end
   end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [NB_DATA-1:0] checksum;

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         checksum <= '0;
      end else if (start_load) begin
         checksum <= '0;
      end else if (word_ready) begin
         checksum <= checksum ^ word_next;
      end
   end

   assign bus.o_checksum = checksum;
`else
   assign bus.o_checksum = '0;
`endif

   assign bus.o_wr_enable  = wr_enable;
   assign bus.o_wr_addr    = wr_addr;
   assign bus.o_wr_data    = wr_data;
   assign bus.o_word_count = word_count;
   assign bus.o_busy       = (state == ST_LOAD);
   assign bus.o_done       = (state == ST_DONE);
   assign bus.o_error      = (state == ST_ERROR);
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized loads
// checked every cycle against a word-level model of the loading rules.
module tb_program_loader;
   localparam int          NB_DATA   = 32;
   localparam int          NB_BYTE   = 8;
   localparam int          NB_ADDR   = 5;
   localparam int          ROM_DEPTH = 30;
   localparam logic [31:0] HALT      = 32'hFFFF_FFFF;

   typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERROR} mphase_t;

   logic clk;
   logic rst_n;

   program_loader_if #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NB_ADDR_CUSTOM(NB_ADDR)) bus ();

   program_loader #(
      .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NB_ADDR_CUSTOM(NB_ADDR),
      .ROM_DEPTH(ROM_DEPTH), .HALT_WORD(HALT)
   ) dut (
      .i_clock(clk),
      .i_reset(rst_n),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int tests = 0;
   int fails = 0;

   // Reference model: bytes received in the current load, words written, XOR of them.
   mphase_t     m_phase;
   int          m_bytes;
   logic [31:0] m_cur;
   int          m_count;
   logic [31:0] m_chk;
   bit          m_to_done;
   bit          m_to_err;

   int          dut_writes;
   logic [31:0] last_addr;
   logic [31:0] last_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_checksum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      return m_chk;
`else
      return 32'h0;
`endif
   endfunction

   task automatic model_reset();
      m_phase   = M_IDLE;
      m_bytes   = 0;
      m_cur     = '0;
      m_count   = 0;
      m_chk     = '0;
      m_to_done = 1'b0;
      m_to_err  = 1'b0;
   endtask

   // One clock cycle: predict, drive, clock, then compare every output.
   task automatic step(input bit start, input bit valid, input logic [7:0] data);
      bit          exp_wr;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      exp_wr   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      if (m_phase == M_LOAD) begin
         if (m_to_done)     m_phase = M_DONE;
         else if (m_to_err) m_phase = M_ERROR;
         m_to_done = 1'b0;
         m_to_err  = 1'b0;
         if (m_phase == M_LOAD && valid) begin
            m_bytes++;
            m_cur = {m_cur[23:0], data};
            if (m_bytes % 4 == 0) begin
               exp_wr   = 1'b1;
               exp_addr = 32'(m_count);
               exp_data = m_cur;
               m_count++;
               m_chk = m_chk ^ m_cur;
               if (m_cur == HALT)            m_to_done = 1'b1;
               else if (m_count == ROM_DEPTH) m_to_err = 1'b1;
            end
         end
      end else if (start) begin
         m_phase = M_LOAD;
         m_bytes = 0;
         m_count = 0;
         m_chk   = '0;
      end

      bus.i_start    = start;
      bus.i_rx_valid = valid;
      bus.i_rx_data  = data;
      @(posedge clk);
      #1;
      bus.i_start    = 1'b0;
      bus.i_rx_valid = 1'b0;

      if (bus.o_wr_enable === 1'b1) begin
         dut_writes++;
         last_addr = 32'(bus.o_wr_addr);
         last_data = bus.o_wr_data;
      end
      check("wr_enable", 32'(bus.o_wr_enable), 32'(exp_wr));
      if (exp_wr) begin
         check("wr_addr", 32'(bus.o_wr_addr), exp_addr);
         check("wr_data", bus.o_wr_data, exp_data);
      end
      check("word_count", 32'(bus.o_word_count), 32'(m_count));
      check("busy", 32'(bus.o_busy), 32'(m_phase == M_LOAD));
      check("done", 32'(bus.o_done), 32'(m_phase == M_DONE));
      check("error", 32'(bus.o_error), 32'(m_phase == M_ERROR));
      check("checksum", bus.o_checksum, exp_checksum());
   endtask

   // Reset for one cycle with random junk on the other inputs; everything must read 0.
   task automatic do_reset();
      rst_n          = 1'b0;
      bus.i_start    = 1'($urandom);
      bus.i_rx_valid = 1'($urandom);
      bus.i_rx_data  = 8'($urandom);
      @(posedge clk);
      #1;
      rst_n          = 1'b1;
      bus.i_start    = 1'b0;
      bus.i_rx_valid = 1'b0;
      model_reset();
      check("rst_wr_enable", 32'(bus.o_wr_enable), 32'h0);
      check("rst_wr_addr", 32'(bus.o_wr_addr), 32'h0);
      check("rst_wr_data", bus.o_wr_data, 32'h0);
      check("rst_word_count", 32'(bus.o_word_count), 32'h0);
      check("rst_busy", 32'(bus.o_busy), 32'h0);
      check("rst_done", 32'(bus.o_done), 32'h0);
      check("rst_error", 32'(bus.o_error), 32'h0);
      check("rst_checksum", bus.o_checksum, 32'h0);
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h0;
      return w;
   endfunction

   // Send one word MSB first; optional idle gaps and ignored mid-load start pulses.
   task automatic send_word(input logic [31:0] w, input bit gaps, input bit noise);
      for (int i = 3; i >= 0; i--) begin
         if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 8'($urandom));
         step(noise && ($urandom_range(0, 7) == 0), 1'b1, w[i*8 +: 8]);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.i_start    = 1'b0;
      bus.i_rx_valid = 1'b0;
      bus.i_rx_data  = '0;
      dut_writes     = 0;
      last_addr      = '0;
      last_data      = '0;
      model_reset();

      // Reset state, then bytes in IDLE are ignored.
      do_reset();
      do_reset();
      repeat (6) step(1'b0, 1'($urandom), 8'($urandom));

      // Start with a same-cycle byte (discarded), then 00 00 00 01.
      step(1'b1, 1'b1, 8'hAB);
      send_word(32'h0000_0001, 1'b0, 1'b0);
      check("first_data", last_data, 32'h0000_0001);
      check("first_addr", last_addr, 32'h0);
      repeat (2) step(1'b0, 1'b0, 8'h00);

      // Three back-to-back words ending in HALT.
      do_reset();
      step(1'b1, 1'b0, 8'h00);
      dut_writes = 0;
      send_word(32'h2002_0005, 1'b0, 1'b0);
      send_word(32'h0000_0000, 1'b0, 1'b0);
      send_word(HALT, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00);
      check("halt_writes", 32'(dut_writes), 32'd3);
      check("halt_last_addr", last_addr, 32'd2);
      check("halt_done", 32'(bus.o_done), 32'h1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      check("halt_checksum", bus.o_checksum, 32'hDFFD_FFFA);
`else
      check("halt_checksum", bus.o_checksum, 32'h0);
`endif

      // Bytes in DONE are ignored; start restarts at address 0.
      dut_writes = 0;
      send_word(HALT, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b1, 8'($urandom));
      check("done_no_write", 32'(dut_writes), 32'd0);
      step(1'b1, 1'b0, 8'h00);
      check("restart_busy", 32'(bus.o_busy), 32'h1);
      check("restart_done", 32'(bus.o_done), 32'h0);
      send_word(rand_word(), 1'b1, 1'b0);
      check("restart_addr", last_addr, 32'h0);

      // Fill memory with non-HALT words and ignored mid-load starts: ERROR.
      for (int k = 1; k < ROM_DEPTH; k++) send_word(rand_word(), 1'b1, 1'b1);
      check("full_writes", 32'(dut_writes), 32'(ROM_DEPTH));
      check("full_last_addr", last_addr, 32'(ROM_DEPTH - 1));
      step(1'b0, 1'b0, 8'h00);
      check("full_error", 32'(bus.o_error), 32'h1);
      dut_writes = 0;
      repeat (5) step(1'b0, 1'b1, 8'($urandom));
      check("error_no_write", 32'(dut_writes), 32'd0);

      // Partial word is discarded by reset.
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h55);
      step(1'b0, 1'b1, 8'h66);
      do_reset();
      step(1'b1, 1'b0, 8'h00);
      dut_writes = 0;
      send_word(32'h0000_0007, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00);
      check("partial_writes", 32'(dut_writes), 32'd1);
      check("partial_data", last_data, 32'h0000_0007);
      check("partial_addr", last_addr, 32'h0);

      // Randomized loads with occasional HALT, gaps and stray starts.
      for (int r = 0; r < 8; r++) begin
         step(1'b1, 1'($urandom), 8'($urandom));
         for (int k = 0; k < int'($urandom_range(1, 12)); k++)
            send_word(($urandom_range(0, 5) == 0) ? HALT : rand_word(), 1'b1, 1'b1);
         repeat (3) step(1'b0, 1'($urandom), 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Sits directly upstream of the program memory write port.
- Receives a byte stream from the debug/UART receive path and packs each 4 bytes into a 32-bit word, MSB first.
- Writes words to sequential program memory addresses starting at 0.
- Stops on a HALT word, or flags an error if memory fills before a HALT arrives.

Parameters:
- NB_DATA, 32, word width; must equal 4*NB_BYTE.
- NB_BYTE, 8, incoming byte width.
- NB_ADDR_CUSTOM, 5, program memory write-address width.
- ROM_DEPTH, 30, number of writable words; must be <= 2**NB_ADDR_CUSTOM.
- HALT_WORD, 32'hFFFF_FFFF, instruction word that terminates loading.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle pulse that arms a new load.
- i_rx_data  in  NB_BYTE  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle.
- o_wr_enable  out  1  program memory write strobe.
- o_wr_addr  out  NB_ADDR_CUSTOM  program memory write address.
- o_wr_data  out  NB_DATA  program memory write data.
- o_busy  out  1  high while in LOAD.
- o_done  out  1  high in DONE; HALT was received and written.
- o_error  out  1  high in ERROR; ROM_DEPTH words were written without a HALT.
- o_word_count  out  NB_ADDR_CUSTOM+1  number of words written in the current load.
- o_checksum  out  NB_DATA  running XOR of written words (see Optional Feature).

Behaviour:
- Reset: on i_reset==0 at a rising edge, all outputs, the byte counter, the address and the shift register go to 0; state goes to IDLE. Reset overrides every other input, including mid-word or mid-load.
- State IDLE:
  - i_start goes to LOAD and clears address, word count, byte counter and checksum.
  - i_rx_valid is ignored.
- State LOAD:
  - Each i_rx_valid shifts i_rx_data into the low byte of the shift register (earlier bytes move up) and increments the 2-bit byte counter.
  - On the 4th byte, the registered outputs on the next edge are: o_wr_enable=1 for exactly one cycle, o_wr_data = assembled word, o_wr_addr = current address.
  - Latency: 1 cycle from the 4th i_rx_valid to o_wr_enable.
  - Address and o_word_count increment in the same cycle o_wr_enable is high. o_wr_addr holds its value when no write is pending.
  - If the assembled word == HALT_WORD, it is written, then state goes to DONE the cycle after the write.
  - Else, if the write was to address ROM_DEPTH-1, state goes to ERROR the cycle after the write.
  - i_start while in LOAD is ignored.
  - Back-to-back i_rx_valid on every cycle must be supported without losing bytes.
- State DONE:
  - o_done=1; no further writes.
  - i_rx_valid is ignored.
  - i_start restarts as from IDLE.
- State ERROR:
  - o_error=1; no further writes.
  - i_start restarts as from IDLE.
- i_start and i_rx_valid in the same cycle from IDLE/DONE/ERROR: the start takes effect and the byte is discarded.
- o_busy=1 only in LOAD.
- o_done and o_error are never high together.
- A partial word (1-3 bytes) at reset or restart is discarded.

Optional Feature:
- Macro PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - o_checksum holds the XOR of every word written in the current load, including HALT_WORD.
  - It updates in the same cycle as o_wr_enable, clears on reset and on start, and holds its value in DONE/ERROR.
- Undefined: o_checksum is tied to 0 and no checksum register is synthesized.

Test Plan:
- Reset, then pulse i_start, then send bytes 00 00 00 01 → o_wr_enable=1 one cycle after the 4th byte with o_wr_addr=0, o_wr_data=32'h0000_0001; o_word_count=1.
- Send words 32'h2002_0005, 32'h0000_0000, 32'hFFFF_FFFF as 12 consecutive-cycle bytes → writes at addresses 0, 1, 2; o_done=1 the cycle after the 3rd write; o_checksum=32'hDFFD_FFFA with the macro defined, 0 without it.
- Send 30 non-HALT words (ROM_DEPTH=30) → last write at address 29; o_error=1 the next cycle; an extra byte causes no write.
- Send 2 bytes, assert i_reset=0 for one cycle, pulse i_start, send 00 00 00 07 → single write of 32'h0000_0007 at address 0; all outputs were 0 during reset.
- In DONE, drive i_rx_valid with data → no write, o_done stays 1; then pulse i_start → o_done=0, o_busy=1, next word written at address 0.
- Pulse i_start in the middle of a load → ignored; the address sequence continues unbroken.
